// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised two-port SRAM model.
package sram_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    typedef enum logic {INIT, READY} seq_state_e;

    function automatic int NB(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency shift register: stage 0 captures at the issue edge, the last
// stage drives D_OUT and only updates when a valid result reaches it.
module sram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0]             vld_q, vld_d;
    logic [RD_LAT-1:0][DATA_W-1:0] data_q, data_d;

    always_comb begin
        vld_d     = vld_q;
        data_d    = data_q;
        vld_d[0]  = in_vld;
        data_d[0] = in_data;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
        if (!vld_d[RD_LAT-1]) data_d[RD_LAT-1] = data_q[RD_LAT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_vld  = vld_q[RD_LAT-1];
    assign out_data = data_q[RD_LAT-1];

endmodule

// File: rtl/sram_2p_param.sv
// 1R+1W synchronous SRAM model with byte-lane masking, write-first forwarding,
// configurable read latency and a post-reset zero-fill sequencer.
module sram_2p_param import sram_pkg::*; #(
    parameter int DATA_W    = 32,
    parameter int BYTE_W    = 8,
    parameter int DEPTH     = 16384,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int RD_LAT    = 1,
    parameter bit INIT_ZERO = 1'b1,
    parameter     INIT_FILE = "",
    localparam int NL       = NB(DATA_W, BYTE_W)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              CS,
    input  logic              WEB,
    input  logic [NL-1:0]     BWEB,
    input  logic              RE,
    input  logic [ADDR_W-1:0] W_ADDR,
    input  logic [ADDR_W-1:0] R_ADDR,
    input  logic [DATA_W-1:0] D_IN,
    output logic [DATA_W-1:0] D_OUT,
    output logic              R_VALID,
    output logic              INIT_BUSY
);

    if (DATA_W % BYTE_W != 0) begin : g_chk_lanes
        $error("DATA_W must be a multiple of BYTE_W");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_chk_lat
        $error("RD_LAT out of range");
    end
    if (DEPTH > (1 << ADDR_W)) begin : g_chk_depth
        $error("DEPTH exceeds address space");
    end

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    // Sized to the full address space so any address indexes cleanly; words
    // at or above DEPTH are never written or returned. INIT_FILE preloading
    // is left to the simulation harness since it cannot be synthesised.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic              ready, w_ok, r_ok, wr_req, rd_req, mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] wr_word, rd_word, mem_wdata;

    always_comb begin
        ready  = (state_q == READY);
        w_ok   = {1'b0, W_ADDR} < DEPTH_X;
        r_ok   = {1'b0, R_ADDR} < DEPTH_X;
        wr_req = ready && CS && !WEB && w_ok;
        rd_req = ready && CS && RE;

        wr_word = mem[W_ADDR];
        for (int i = 0; i < NL; i++) begin
            if (!BWEB[i]) wr_word[i*BYTE_W +: BYTE_W] = D_IN[i*BYTE_W +: BYTE_W];
        end

        // Write-first: a same-edge write to the read address is forwarded.
        rd_word = '0;
        if (r_ok) rd_word = (wr_req && (W_ADDR == R_ADDR)) ? wr_word : mem[R_ADDR];

        mem_we    = ready ? wr_req  : 1'b1;
        mem_waddr = ready ? W_ADDR  : cnt_q;
        mem_wdata = ready ? wr_word : '0;
    end

    always_ff @(posedge CK) begin
        if (!RST && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = READY;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= INIT_ZERO ? INIT : READY;
            cnt_q   <= '0;
            busy_q  <= INIT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign INIT_BUSY = busy_q;

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (CK),
        .rst      (RST),
        .in_vld   (rd_req),
        .in_data  (rd_word),
        .out_vld  (R_VALID),
        .out_data (D_OUT)
    );

endmodule

// File: tb/tb_sram_2p_param.sv
// Scoreboard bench: one RD_LAT=1 and one RD_LAT=3 instance share stimulus.
module tb_sram_2p_param;

    localparam int DW = 32;
    localparam int AW = 7;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0, web = 1'b1, re = 1'b0;
    logic [3:0]    bweb = '1;
    logic [AW-1:0] wa = '0, ra = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout_a, dout_b;
    logic          rv_a, rv_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int na, nb;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    sram_2p_param #(.DATA_W(32), .BYTE_W(8), .DEPTH(64), .ADDR_W(AW), .RD_LAT(1),
                    .INIT_ZERO(1'b1), .INIT_FILE("")) u_a (
        .CK(ck), .RST(rst), .CS(cs), .WEB(web), .BWEB(bweb), .RE(re),
        .W_ADDR(wa), .R_ADDR(ra), .D_IN(din),
        .D_OUT(dout_a), .R_VALID(rv_a), .INIT_BUSY(busy_a));

    sram_2p_param #(.DATA_W(32), .BYTE_W(8), .DEPTH(64), .ADDR_W(AW), .RD_LAT(3),
                    .INIT_ZERO(1'b1), .INIT_FILE("")) u_b (
        .CK(ck), .RST(rst), .CS(cs), .WEB(web), .BWEB(bweb), .RE(re),
        .W_ADDR(wa), .R_ADDR(ra), .D_IN(din),
        .D_OUT(dout_b), .R_VALID(rv_b), .INIT_BUSY(busy_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge ck) begin
        if (rv_a === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_valid: got data %h expected no valid", dout_a);
            end else begin
                ea = qa.pop_front();
                chk("a_data", dout_a, ea.data);
                chk("a_latency", cyc, ea.cyc);
            end
        end else if (rv_a !== 1'b0) begin
            checks++; errors++;
            $display("FAIL a_valid_x: got %b expected 0/1", rv_a);
        end
    end

    always @(negedge ck) begin
        if (rv_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_valid: got data %h expected no valid", dout_b);
            end else begin
                eb = qb.pop_front();
                chk("b_data", dout_b, eb.data);
                chk("b_latency", cyc, eb.cyc);
            end
        end else if (rv_b !== 1'b0) begin
            checks++; errors++;
            $display("FAIL b_valid_x: got %b expected 0/1", rv_b);
        end
    end

    // One request cycle; a read pushes its hand-computed result for both instances.
    task automatic op(input logic we, input logic [AW-1:0] w, input logic [31:0] d,
                      input logic [3:0] bw, input logic rd, input logic [AW-1:0] r,
                      input logic [31:0] exp);
        @(negedge ck);
        cs = we | rd; web = ~we; wa = w; din = d; bweb = bw; re = rd; ra = r;
        if (rd) begin
            qa.push_back('{exp, cyc + 1});
            qb.push_back('{exp, cyc + 3});
        end
        @(posedge ck);
    endtask

    task automatic idle(input int n);
        @(negedge ck);
        cs = 1'b0; web = 1'b1; re = 1'b0; bweb = '1;
        repeat (n) @(posedge ck);
    endtask

    task automatic wait_init(output int ca, output int cb);
        ca = 0; cb = 0;
        for (int k = 0; k < 200 && (busy_a || busy_b); k++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            @(negedge ck);
        end
    endtask

    initial begin
        repeat (2) @(negedge ck);
        chk("rst_dout_a", dout_a, 0);
        chk("rst_valid_a", {31'b0, rv_a}, 0);
        chk("rst_busy_a", {31'b0, busy_a}, 1);
        chk("rst_dout_b", dout_b, 0);
        chk("rst_busy_b", {31'b0, busy_b}, 1);

        // Requests held during init must be ignored.
        cs = 1'b1; re = 1'b1; web = 1'b0; bweb = '0; wa = 63; ra = 63; din = '1;
        rst = 1'b0;
        wait_init(na, nb);
        cs = 1'b0; re = 1'b0; web = 1'b1; bweb = '1;
        chk("init_cycles_a", na, 64);
        chk("init_cycles_b", nb, 64);

        op(0, 0, 0, '1, 1, 63, 32'h0000_0000);
        op(1, 5, 32'hDEAD_BEEF, 4'b0000, 0, 0, 0);
        op(0, 0, 0, '1, 1, 5, 32'hDEAD_BEEF);
        idle(3);
        @(negedge ck);
        chk("hold_dout_a", dout_a, 32'hDEAD_BEEF);
        chk("hold_valid_a", {31'b0, rv_a}, 0);
        chk("hold_dout_b", dout_b, 32'hDEAD_BEEF);

        op(1, 7, 32'h1122_3344, 4'b0000, 0, 0, 0);
        op(1, 7, 32'hAABB_CCDD, 4'b1010, 1, 7, 32'h11BB_33DD);
        op(1, 0, 32'hA0A0_A0A0, 4'b0000, 0, 0, 0);
        op(1, 1, 32'hB1B1_B1B1, 4'b0000, 0, 0, 0);
        op(1, 2, 32'hC2C2_C2C2, 4'b0000, 1, 7, 32'h11BB_33DD);

        // Back-to-back reads with concurrent writes elsewhere.
        op(1, 8, 32'h1234_5678, 4'b0000, 1, 0, 32'hA0A0_A0A0);
        op(1, 9, 32'h9999_9999, 4'b0000, 1, 1, 32'hB1B1_B1B1);
        op(0, 0, 0, '1, 1, 2, 32'hC2C2_C2C2);

        // Out-of-range: write dropped, read returns zero with valid.
        op(1, 6, 32'h6666_6666, 4'b0000, 0, 0, 0);
        op(1, 70, 32'h5555_5555, 4'b0000, 1, 70, 32'h0000_0000);
        op(0, 0, 0, '1, 1, 6, 32'h6666_6666);

        // Fully masked write is a no-op, even with a same-address read.
        op(1, 5, 32'h0000_0000, 4'b1111, 1, 5, 32'hDEAD_BEEF);
        op(0, 0, 0, '1, 1, 5, 32'hDEAD_BEEF);
        op(0, 0, 0, '1, 1, 8, 32'h1234_5678);
        idle(4);

        // Reset with reads in flight: nothing queued may emerge.
        op(0, 0, 0, '1, 1, 1, 32'hB1B1_B1B1);
        op(0, 0, 0, '1, 1, 2, 32'hC2C2_C2C2);
        #1;
        rst = 1'b1;
        cs = 1'b0; re = 1'b0; web = 1'b1; bweb = '1;
        qa.delete();
        qb.delete();
        @(negedge ck);
        chk("flush_valid_a", {31'b0, rv_a}, 0);
        chk("flush_dout_a", dout_a, 0);
        chk("flush_busy_a", {31'b0, busy_a}, 1);
        chk("flush_valid_b", {31'b0, rv_b}, 0);
        chk("flush_dout_b", dout_b, 0);
        chk("flush_busy_b", {31'b0, busy_b}, 1);
        repeat (3) @(negedge ck);
        rst = 1'b0;
        wait_init(na, nb);
        chk("reinit_cycles_a", na, 64);
        chk("reinit_cycles_b", nb, 64);

        op(0, 0, 0, '1, 1, 5, 32'h0000_0000);
        op(0, 0, 0, '1, 1, 7, 32'h0000_0000);
        idle(5);
        @(negedge ck);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_2p_param.md
# sram_2p_param

Parametrised two-port (1R + 1W) synchronous SRAM model for the token-engine testbench and behavioural builds: the next generation of the 1024×24 / 16K×32 memory models. Adds byte-lane write masking, a configurable read-latency pipeline with a valid strobe, defined read-during-write forwarding and a post-reset zero-initialisation sequencer. It sits wherever the engine instantiates activation/weight buffers and is a drop-in replacement once widths are set.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of BYTE_W
- BYTE_W, 8, bits per write-mask lane; NB = DATA_W/BYTE_W
- DEPTH, 16384, number of words; need not be a power of two
- ADDR_W, $clog2(DEPTH), address width
- RD_LAT, 1, read latency in cycles, legal 1..3
- INIT_ZERO, 1, 1 = zero the whole array after every reset
- INIT_FILE, "", hex file loaded at time 0 when non-empty (sim only; use with INIT_ZERO=0)

- CK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- CS  in  1  chip select, gates both ports
- WEB  in  1  write enable, active-low
- BWEB  in  NB  per-lane write mask, active-low (0 = write lane)
- RE  in  1  read enable, active-high
- W_ADDR  in  ADDR_W  write address
- R_ADDR  in  ADDR_W  read address
- D_IN  in  DATA_W  write data
- D_OUT  out  DATA_W  read data
- R_VALID  out  1  D_OUT carries a fresh read result this cycle
- INIT_BUSY  out  1  zero-init in progress; requests dropped

## Operation
- Sequencer FSM, states INIT, READY. RST → INIT if INIT_ZERO=1, else READY.
- INIT: counter 0..DEPTH-1 writes all-zero word per cycle; after writing DEPTH-1 → READY. INIT_BUSY=1 exactly in INIT.
- In INIT all CS/RE/WEB requests are ignored: no array write, no R_VALID.
- READY write: CS && !WEB at edge → lane i of mem[W_ADDR] takes D_IN lane i where BWEB[i]=0; other lanes unchanged. BWEB all-ones = no-op.
- READY read: CS && RE at edge → read issued; WEB does not block reads (true 2-port).
- Read-during-write, same address, same edge: write-first; returned word = old word with masked-written lanes replaced by D_IN.
- Different addresses: independent.
- Address ≥ DEPTH: write dropped; read returns 0 with R_VALID=1.
- No read issued: D_OUT holds last value (never X); R_VALID=0.
- Reset at any time: pipeline flushed, R_VALID=0, D_OUT=0, init restarts at address 0; array contents undefined only for INIT_ZERO=0 (retained in model).

## Timing
- Reset values: D_OUT=0, R_VALID=0, INIT_BUSY=INIT_ZERO.
- INIT lasts exactly DEPTH cycles after RST deasserts; first accepted request on the edge after INIT_BUSY falls.
- Read latency: issued at edge n → D_OUT/R_VALID updated at edge n+RD_LAT-1... i.e. RD_LAT=1 means valid in the cycle following the issue edge; each extra stage adds one cycle.
- Full throughput: one read and one write per cycle, back-to-back, no bubbles.
- Forwarding applies only at the issue edge; writes during the RD_LAT-1 in-flight cycles do not modify in-flight data.
- Write at edge n visible to any read issued at edge ≥ n.

## Structure
- Package sram_pkg: lane-count function NB(DATA_W,BYTE_W), RD_LAT_MIN=1, RD_LAT_MAX=3, state enum {INIT, READY}.
- Sub-module sram_rd_pipe: RD_LAT-deep data+valid shift register with async reset, holds D_OUT when no valid enters the last stage.
- Elaboration checks: DATA_W % BYTE_W == 0, RD_LAT in range, DEPTH ≤ 2**ADDR_W.

## Test plan
- DEPTH=64, INIT_ZERO=1: release RST, hold CS/RE → INIT_BUSY high exactly 64 cycles, no R_VALID; then read addr 63 → 0x00000000.
- Write 0xDEADBEEF to 5, next cycle read 5, RD_LAT=1 → D_OUT=0xDEADBEEF, R_VALID one cycle later then 0, D_OUT held.
- Addr 7 = 0x11223344; write 0xAABBCCDD BWEB=4'b1010 to 7 and read 7 same edge → 0x11BB33DD.
- RD_LAT=3: reads to 0,1,2 on consecutive edges → three consecutive R_VALID cycles, data in order, first 3 cycles after issue.
- Read addr 70 with DEPTH=64, ADDR_W=7 → D_OUT=0, R_VALID=1; write to 70 leaves addr 6 unchanged.
- Assert RST with two reads in flight (RD_LAT=3) → R_VALID=0, D_OUT=0 immediately, INIT_BUSY=1, in-flight results never appear.
